// File: rtl/rs232_ser_pkg.sv
// Shared definitions for the RS232 serial blocks (rs232_ser, and the
// rs232_des receiver that pairs with it).
//   DATA_BITS     : payload bits per frame
//   DEF_CLK_FREQ  : default system clock in Hz
//   DEF_BAUD_RATE : default serial bit rate in bits/s
//   state_t       : frame state encoding shared by transmitter and receiver
//   calc_divisor  : clocks per bit, integer-truncated
package rs232_ser_pkg;

  localparam int DATA_BITS     = 8;
  localparam int DEF_CLK_FREQ  = 100000000;
  localparam int DEF_BAUD_RATE = 9600;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Truncation error is tolerated; there is no fractional accumulation.
  function automatic int calc_divisor(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/rs232_baud_gen.sv
// Bit-period timer for the RS232 blocks.
// Counts 0..DIVISOR-1 and wraps; tick marks the last clock of each bit.
// While clr is high the count is held at 0, so the first bit after clr
// drops lasts exactly DIVISOR clocks.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr   : hold counter at zero (no tick while high)
//   tick  : high during the final clock of a bit period
module rs232_baud_gen #(
  parameter int DIVISOR = 10416
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int              CNT_W = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/rs232_ser.sv
// RS232 transmitter, 8 data bits, no parity, 1 or 2 stop bits.
// Accepts a byte over a level-request / pulse-acknowledge handshake and
// shifts it out LSB first at BAUD_RATE.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   tx_data : byte to send, valid while tx_req is high
//   tx_req  : producer has a byte available
//   tx_ack  : one-cycle pulse, tx_data is captured at this clock edge
//   tx      : registered serial line, idles high
//   busy    : a frame is in progress
module rs232_ser
  import rs232_ser_pkg::*;
#(
  parameter int CLK_FREQ  = DEF_CLK_FREQ,
  parameter int BAUD_RATE = DEF_BAUD_RATE,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_req,
  output logic       tx_ack,
  output logic       tx,
  output logic       busy
);

  localparam int         DIVISOR   = calc_divisor(CLK_FREQ, BAUD_RATE);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  state_t     state, state_nxt;
  logic [7:0] shift_reg, shift_nxt;
  logic [2:0] bit_idx, bit_idx_nxt;
  logic       tx_nxt;
  logic       tick;
  logic       clr;

  // Holding the timer cleared in IDLE aligns every bit period to the
  // accept edge, so START lasts exactly DIVISOR clocks.
  assign clr = (state == IDLE);

  rs232_baud_gen #(
    .DIVISOR (DIVISOR)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      tx        <= 1'b1;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_idx   <= bit_idx_nxt;
      tx        <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    bit_idx_nxt = bit_idx;
    tx_ack      = 1'b0;
    tx_nxt      = 1'b1;

    case (state)
      IDLE: begin
        // rst_n gating keeps the acknowledge quiet while the registers
        // cannot actually capture the byte.
        if (tx_req && rst_n) begin
          tx_ack      = 1'b1;
          shift_nxt   = tx_data;
          bit_idx_nxt = '0;
          state_nxt   = START;
        end
      end
      START: begin
        if (tick) begin
          bit_idx_nxt = '0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_nxt = {1'b0, shift_reg[7:1]};
          if (bit_idx == LAST_DATA) begin
            bit_idx_nxt = '0;
            state_nxt   = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        // bit_idx is reused to count stop-bit periods.
        if (tick) begin
          if (bit_idx == LAST_STOP) begin
            bit_idx_nxt = '0;
            state_nxt   = IDLE;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // The line is registered from the next state so it changes on the
    // same edge as the state, giving tx low on the first clock after accept.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rs232_ser.sv
// Self-checking bench for rs232_ser at CLK_FREQ=40, BAUD_RATE=10
// (4 clocks per bit) with two stop bits. Every clock of every frame is
// compared against the line level computed from the frame layout
// (start bit, LSB..MSB, stop bits), and each frame is also decoded at
// mid-bit and compared with the byte sent.
module tb_rs232_ser;

  localparam int CLK_FREQ  = 40;
  localparam int BAUD_RATE = 10;
  localparam int STOP_BITS = 2;
  localparam int D         = CLK_FREQ / BAUD_RATE;
  localparam int FRAME     = (9 + STOP_BITS) * D;
  localparam int ACK_LIMIT = 4 * FRAME;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_ack;
  logic       tx;
  logic       busy;

  int n_vec    = 0;
  int n_miscmp = 0;

  always #5 clk = ~clk;

  rs232_ser #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .STOP_BITS (STOP_BITS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .tx_ack  (tx_ack),
    .tx      (tx),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_miscmp++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, want, $time);
    end
  endtask

  // Line level k clocks after the accept edge for byte d.
  function automatic logic line_model(input logic [7:0] d, input int k);
    int b;
    b = k / D;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_line", 32'(tx), 1);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_ack", 32'(tx_ack), 0);
    end
  endtask

  // Raise the request with byte d and wait (bounded) for the acknowledge.
  task automatic send_byte(input logic [7:0] d, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    @(posedge clk); #1;
    tx_data = d;
    tx_req  = 1'b1;
    while (!seen && lat < ACK_LIMIT) begin
      @(negedge clk);
      lat++;
      seen = (tx_ack === 1'b1);
    end
    chk("ack_seen", 32'(seen), 1);
  endtask

  // Called at the negedge where tx_ack for byte d is visible. After the
  // accept edge the request becomes nreq/nd, immediately (req_at=0) or
  // at frame clock req_at (req_at>0, data scrambled until then).
  task automatic expect_frame(input logic [7:0] d, input bit nreq,
                              input logic [7:0] nd, input int req_at);
    logic [7:0] rx;
    rx = '0;
    @(posedge clk); #1;
    if (req_at == 0) begin
      tx_req  = nreq;
      tx_data = nd;
    end else begin
      tx_req  = 1'b0;
      tx_data = 8'($urandom);
    end
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      chk("line", 32'(tx), 32'(line_model(d, k)));
      chk("busy", 32'(busy), 1);
      chk("ack_in_frame", 32'(tx_ack), 0);
      if ((k % D == D / 2) && (k / D >= 1) && (k / D <= 8)) rx[k/D-1] = tx;
      if (req_at > 0 && k == req_at) begin
        tx_req  = nreq;
        tx_data = nd;
      end
    end
    chk("decoded_byte", 32'(rx), 32'(d));
    @(negedge clk);
    chk("gap_line", 32'(tx), 1);
    chk("gap_busy", 32'(busy), 0);
    chk("gap_ack", 32'(tx_ack), 32'(nreq));
  endtask

  initial begin
    int         lat;
    bit         pending;
    logic [7:0] pend_d;
    logic [7:0] d;
    logic [7:0] nd;
    int         mode;

    // Reset with a request already pending: nothing may be acknowledged.
    rst_n   = 1'b0;
    tx_req  = 1'b1;
    tx_data = 8'hA5;
    repeat (3) @(negedge clk);
    chk("rst_line", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(tx_ack), 0);
    tx_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(4);

    // Single frames.
    send_byte(8'hAA, lat);
    chk("ack_latency", 32'(lat), 1);
    expect_frame(8'hAA, 1'b0, 8'h00, 0);
    idle_check(3);
    send_byte(8'h55, lat);
    chk("ack_latency", 32'(lat), 1);
    expect_frame(8'h55, 1'b0, 8'h00, 0);

    // Back-to-back stream with the request held high.
    send_byte(8'h01, lat);
    expect_frame(8'h01, 1'b1, 8'h80, 0);
    expect_frame(8'h80, 1'b1, 8'hFF, 0);
    expect_frame(8'hFF, 1'b0, 8'h00, 0);

    // Request raised mid-frame waits for the idle slot.
    send_byte(8'h3C, lat);
    expect_frame(8'h3C, 1'b1, 8'hC3, FRAME / 2);
    expect_frame(8'hC3, 1'b0, 8'h00, 0);

    // Reset during data bit 4 (0xEF has bit 4 low).
    send_byte(8'hEF, lat);
    @(posedge clk); #1;
    tx_req = 1'b0;
    repeat (5 * D + 1) @(negedge clk);
    chk("pre_rst_line", 32'(tx), 0);
    chk("pre_rst_busy", 32'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_line", 32'(tx), 1);
    chk("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(2 * FRAME);
    send_byte(8'h96, lat);
    chk("ack_latency", 32'(lat), 1);
    expect_frame(8'h96, 1'b0, 8'h00, 0);

    // Full byte sweep, streamed.
    send_byte(8'h00, lat);
    for (int i = 0; i < 256; i++) begin
      expect_frame(8'(i), (i != 255), 8'(i + 1), 0);
    end

    // Randomized bytes, gaps and request timing.
    pending = 1'b0;
    pend_d  = 8'h00;
    for (int n = 0; n < 24; n++) begin
      if (!pending) begin
        idle_check($urandom_range(0, 3));
        d = 8'($urandom);
        send_byte(d, lat);
        chk("ack_latency", 32'(lat), 1);
      end else begin
        d = pend_d;
      end
      mode = $urandom_range(0, 2);
      nd   = 8'($urandom);
      case (mode)
        0:       expect_frame(d, 1'b0, 8'h00, 0);
        1:       expect_frame(d, 1'b1, nd, 0);
        default: expect_frame(d, 1'b1, nd, $urandom_range(1, FRAME - 1));
      endcase
      pending = (mode != 0);
      pend_d  = nd;
    end
    if (pending) expect_frame(pend_d, 1'b0, 8'h00, 0);
    idle_check(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not reach the end, %0d miscompares so far", n_miscmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rs232_ser.md
Name: rs232_ser

Overview:
RS232 transmitter, 8N1 (optionally 8N2). It is the transmit counterpart to rs232_des. It accepts a byte from the fabric over a req/ack handshake and shifts it out on tx, LSB first, at BAUD_RATE. It pairs with rs232_des in the serial_comm top level to form the full UART link.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz.
BAUD_RATE, 9600, serial bit rate in bits/s.
STOP_BITS, 1, number of stop bits; legal values are 1 and 2.
DIVISOR (localparam), CLK_FREQ/BAUD_RATE with integer truncation (10416 at defaults), clocks per bit; must be >= 2.

Ports:
clk      input   1  system clock, rising-edge.
rst_n    input   1  reset, asynchronous, active-low.
tx_data  input   8  byte to send; must be valid while tx_req=1.
tx_req   input   1  level request from the producer: a byte is available.
tx_ack   output  1  one-cycle pulse: tx_data has been captured.
tx       output  1  serial line out, registered, idles high.
busy     output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (async assert, sync release):
  - tx=1, tx_ack=0, busy=0.
  - state=IDLE; baud counter, bit index and shift register cleared.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - If tx_req=1 at a rising edge, load shift_reg<=tx_data, pulse tx_ack=1 for that cycle only, and go to START.
  - tx_req=0 leaves the block in IDLE with tx=1.
- START: tx=0 for exactly DIVISOR clocks, then go to DATA with bit index 0.
- DATA:
  - tx=shift_reg[0] for DIVISOR clocks, then shift right and increment the bit index.
  - After bit 7 completes, go to STOP.
- STOP: tx=1 for STOP_BITS*DIVISOR clocks, then go to IDLE.
- Latency: tx falls on the first clock after the accept edge.
- Frame timing:
  - Frame length = (9+STOP_BITS)*DIVISOR clocks from the first tx low to the end of the last stop bit.
  - One mandatory IDLE cycle (tx=1) follows every frame.
- Streaming: if tx_req is still 1 in that IDLE cycle, the next byte is accepted there.
  - Producer must present the next tx_data by the cycle after tx_ack.
  - Back-to-back period = (9+STOP_BITS)*DIVISOR+1 clocks.
- Producer rules:
  - The producer drops tx_req (or changes tx_data) only after seeing tx_ack.
  - tx_req asserted while busy=1 is not acknowledged; it waits for IDLE.
  - tx_data changes while busy=1 have no effect on the current frame.
- Baud counter:
  - Counts 0..DIVISOR-1 and reloads at 0 on each bit boundary.
  - Width is clog2(DIVISOR).
  - Truncation error is accepted; no fractional accumulation.
- Reset mid-frame: tx returns high immediately (async). No partial-frame recovery; the byte is lost, the producer resends.
- tx_ack is never asserted outside IDLE and never for two consecutive cycles. The exception is streaming with the mandatory idle gap, where pulses are at least one frame apart.

Decomposition:
- Shared header rs232_defs.vh, also used by rs232_des:
  - DATA_BITS=8.
  - State encodings IDLE/START/DATA/STOP.
  - Divisor computation macro.
  - Default CLK_FREQ/BAUD_RATE.
- Optional sub-module rs232_baud_gen:
  - Parameter DIVISOR.
  - Inputs clk, rst_n, clr; output tick.
  - Reusable by rs232_des.
- Shift/bit-index logic stays inline in rs232_ser.

Test Plan:
1. Defaults, send 0xAA: tx_req=1 with tx_data=0xAA.
   - tx_ack pulses one cycle.
   - Line samples at the mid-bit of each 104160 ns bit read 0,0,1,0,1,0,1,0,1,1 (start, LSB..MSB, stop).
   - busy falls after 10*DIVISOR clocks.
2. Send 0x55: line reads 0,1,0,1,0,1,0,1,0,1.
   - Start-bit falling edge to stop-bit end = 104160*10 ns ±10 ns.
3. Streaming 0x01,0x80,0xFF with tx_req held high and data updated on each tx_ack:
   - Three tx_ack pulses exactly 10*DIVISOR+1 clocks apart.
   - Decoded bytes match in order.
4. tx_req asserted mid-frame with a different byte:
   - No tx_ack until IDLE.
   - Current frame bits are unchanged.
   - Second byte is sent afterwards.
5. rst_n low at bit 4 of a frame:
   - tx=1 and busy=0 within the same cycle.
   - After release with no tx_req, tx stays 1.
   - A new request transmits a clean frame.
6. Loopback with CLK_FREQ=40, BAUD_RATE=10 (DIVISOR=4), STOP_BITS=2, tx wired to rs232_des rx:
   - Sweep 0x00..0xFF.
   - rx_data equals every sent byte, with rx_req per byte acknowledged.
   - Each frame is 11*4 clocks.
